// File: rtl/sw_reg_r_bank.sv
// Software-readable multi-channel register bank on Wishbone with freeze/snapshot view and sticky update flags.
// Optional build macro SW_REG_R_BANK_ERR_EN: illegal writes and unmapped offsets answer with wb_err_o.
module sw_reg_r_bank #(
   parameter logic [31:0] C_BASEADDR  = 32'h0000_0000,
   parameter logic [31:0] C_HIGHADDR  = 32'h0000_007F,
   parameter int unsigned C_NUM_REGS  = 4,
   parameter int unsigned C_REG_WIDTH = 32
) (
   input  logic                              wb_clk_i,
   input  logic                              wb_rst_i,
   input  logic [C_NUM_REGS*C_REG_WIDTH-1:0] fabric_data_in,
   input  logic [C_NUM_REGS-1:0]             fabric_valid,
   input  logic                              wb_cyc_i,
   input  logic                              wb_stb_i,
   input  logic                              wb_we_i,
   input  logic [3:0]                        wb_sel_i,
   input  logic [31:0]                       wb_adr_i,
   input  logic [31:0]                       wb_dat_i,
   output logic [31:0]                       wb_dat_o,
   output logic                              wb_ack_o,
   output logic                              wb_err_o,
   output logic                              snap_active_o
);

   localparam int unsigned N        = C_NUM_REGS;
   localparam int unsigned W        = C_REG_WIDTH;
   localparam logic [29:0] OFF_CTRL = 30'(N);
   localparam logic [29:0] OFF_STAT = 30'(N + 1);
   localparam logic [31:0] SPAN     = C_HIGHADDR - C_BASEADDR;

   logic [W-1:0]  live_q [N];
   logic [W-1:0]  live_d [N];
   logic [W-1:0]  view_q [N];
   logic [W-1:0]  view_d [N];
   logic [N-1:0]  upd_q, upd_d;
   logic          freeze_q, freeze_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic [31:0]   dat_q, dat_d;

   logic [31:0]   rel_c;
   logic [29:0]   off_c;
   logic          req_c, accept_c, mapped_c, ctrl_wr_c, snap_c, err_resp_c;
   logic [31:0]   rd_data_c;
   logic          unused_c;

   // Out-of-window addresses wrap to a large relative offset, so one compare covers both bounds.
   assign rel_c     = wb_adr_i - C_BASEADDR;
   assign off_c     = rel_c[31:2];
   assign req_c     = wb_cyc_i & wb_stb_i & (rel_c <= SPAN);
   assign accept_c  = req_c & ~ack_q & ~err_q;
   assign mapped_c  = (off_c <= OFF_STAT);
   assign ctrl_wr_c = accept_c & wb_we_i & (off_c == OFF_CTRL) & wb_sel_i[0];
   assign snap_c    = ctrl_wr_c & wb_dat_i[1];
   assign unused_c  = ^{wb_sel_i[3:1], wb_dat_i[31:2], rel_c[1:0]};

`ifdef SW_REG_R_BANK_ERR_EN
   assign err_resp_c = ~mapped_c | (wb_we_i & (off_c != OFF_CTRL));
`else
   assign err_resp_c = 1'b0;
`endif

   // Next-state for channel storage, flags and the bus response.
   always_comb begin
      upd_d     = (snap_c ? '0 : upd_q) | fabric_valid;
      freeze_d  = ctrl_wr_c ? wb_dat_i[0] : freeze_q;
      rd_data_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         live_d[i] = fabric_valid[i] ? fabric_data_in[i*W +: W] : live_q[i];
         view_d[i] = view_q[i];
         if (!freeze_q)
            view_d[i] = live_d[i];
         else if (snap_c)
            view_d[i] = live_q[i];
      end
      if (!wb_we_i) begin
         if (off_c == OFF_CTRL)
            rd_data_c = 32'(freeze_q);
         else if (off_c == OFF_STAT)
            rd_data_c = 32'(upd_q);
         else
            for (int unsigned i = 0; i < N; i++)
               if (off_c == 30'(i))
                  rd_data_c = 32'(view_d[i]);
      end
      ack_d = accept_c & ~err_resp_c;
      err_d = accept_c & err_resp_c;
      dat_d = accept_c ? rd_data_c : dat_q;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int unsigned i = 0; i < N; i++) begin
            live_q[i] <= '0;
            view_q[i] <= '0;
         end
         upd_q    <= '0;
         freeze_q <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         dat_q    <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            live_q[i] <= live_d[i];
            view_q[i] <= view_d[i];
         end
         upd_q    <= upd_d;
         freeze_q <= freeze_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         dat_q    <= dat_d;
      end
   end

   assign wb_dat_o      = dat_q;
   assign wb_ack_o      = ack_q;
   assign wb_err_o      = err_q;
   assign snap_active_o = freeze_q;

endmodule
